// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: direction encoding,
// the per-beat mode bundle carried down the pipe, and the data-width check.
package barrel_shifter_pkg;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Everything a beat needs besides its data and remaining shift bits.
    typedef struct packed {
        logic lr;   // DIR_LEFT / DIR_RIGHT
        logic al;   // sign-fill on right shifts
        logic rot;  // rotate instead of shift
    } mode_t;

    function automatic bit width_ok(input int w);
        return (w >= 2) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered stage of the barrel shifter: conditionally shifts by 2^K
// (selected by shamt bit K) and holds the beat under valid/ready backpressure.
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int W  = 32,
    parameter int SW = 5,
    parameter int K  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [W-1:0]  data_i,
    input  logic [SW-1:0] shamt_i,
    input  mode_t         mode_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [W-1:0]  data_o,
    output logic [SW-1:0] shamt_o,
    output mode_t         mode_o
);

    localparam int S = 1 << K;

    logic          valid_q;
    logic [W-1:0]  data_q;
    logic [SW-1:0] shamt_q;
    mode_t         mode_q;

    logic [W-1:0]  shifted;
    logic [S-1:0]  fill;
    logic [W-1:0]  data_d;
    logic [SW-1:0] shamt_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        shifted = data_i;
        fill    = '0;
        unique case (mode_i.lr)
            DIR_LEFT: begin
                fill    = mode_i.rot ? data_i[W-1:W-S] : '0;
                shifted = {data_i[W-S-1:0], fill};
            end
            DIR_RIGHT: begin
                // Arithmetic right keeps the MSB unchanged stage to stage, so
                // the current MSB is always the operand's original sign bit.
                fill    = mode_i.rot ? data_i[S-1:0] : {S{mode_i.al & data_i[W-1]}};
                shifted = {fill, data_i[W-1:S]};
            end
        endcase
        data_d  = shamt_i[K] ? shifted : data_i;
        shamt_d = shamt_i & ~(SW'(1) << K);
    end

    // A stage can take a new beat when empty or when its beat leaves now.
    assign ready_o = !valid_q || ready_i;

    // NOTE: state is updated with non-blocking assignments so each stage
    // captures its upstream neighbour's pre-edge value, never a same-edge update.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data and mode are cleared along with valid so the output
            // bus reads zero after reset instead of a discarded beat.
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_d;
                mode_q  <= mode_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: $clog2(W) registered stages, stage k shifting by
// 2^k. Define BARREL_SHIFTER_PIPE_ROTATE_EN to add the ROT port (rotate mode).
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter  int W  = 32,
    localparam int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] shamt,
    input  logic          LR,
    input  logic          AL,
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
    input  logic          ROT,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  dout
);

    if (!width_ok(W)) begin : g_width_check
        $error("barrel_shifter_pipe: W must be a power of two and at least 2");
    end

    // Index k is the input of stage k; index SW is the pipeline output.
    logic [SW:0]   valid_c;
    logic [SW:0]   ready_c;
    logic [W-1:0]  data_c  [SW+1];
    logic [SW-1:0] shamt_c [SW+1];
    mode_t         mode_c  [SW+1];

    logic rot_in;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
    assign rot_in = ROT;
`else
    assign rot_in = 1'b0;
`endif

    assign valid_c[0] = in_valid;
    assign data_c[0]  = din;
    assign shamt_c[0] = shamt;
    assign mode_c[0]  = '{lr: LR, al: AL, rot: rot_in};

    for (genvar k = 0; k < SW; k++) begin : g_stage
        barrel_shift_stage #(
            .W  (W),
            .SW (SW),
            .K  (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid_i (valid_c[k]),
            .ready_o (ready_c[k]),
            .data_i  (data_c[k]),
            .shamt_i (shamt_c[k]),
            .mode_i  (mode_c[k]),
            .valid_o (valid_c[k+1]),
            .ready_i (ready_c[k+1]),
            .data_o  (data_c[k+1]),
            .shamt_o (shamt_c[k+1]),
            .mode_o  (mode_c[k+1])
        );
    end

    assign ready_c[SW] = out_ready;
    // Nothing is accepted while reset is held, even though stage 0 is ready.
    assign in_ready    = ready_c[0] & ~rst;
    assign out_valid   = valid_c[SW];
    assign dout        = data_c[SW];

    // The last stage's shift bits and mode have no consumer.
    logic unused_tail;
    assign unused_tail = ^{shamt_c[SW], mode_c[SW]};

endmodule
